// File: rtl/router_pkg.sv
// Shared router definitions: packet geometry, direction codes, port indices
// and the round-robin pointer advance used by the merge stage.
package router_pkg;

    localparam int PKT_W = 34;
    localparam int X_HI  = 29;
    localparam int X_LO  = 28;
    localparam int Y_HI  = 27;
    localparam int Y_LO  = 26;

    localparam logic [1:0] WEST  = 2'b00;
    localparam logic [1:0] NORTH = 2'b01;
    localparam logic [1:0] SOUTH = 2'b10;
    localparam logic [1:0] EAST  = 2'b11;

    localparam int IDX_W = 0;
    localparam int IDX_N = 1;
    localparam int IDX_S = 2;
    localparam int IDX_E = 3;
    localparam int IDX_P = 4;

    // Pointer moves to the port just after the winner, wrapping P back to W.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx == 3'(IDX_P)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/router_merge_arb_5_if.sv
// Merge-stage bus: five packed request channels in, one valid/ready link out.
// With ROUTER_MERGE_GRANT_CNT_EN defined, per-source grant counts are carried too.
interface router_merge_arb_5_if #(
    parameter int WIDTH  = 34,
    parameter int NUM_IN = 5
`ifdef ROUTER_MERGE_GRANT_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
`ifdef ROUTER_MERGE_GRANT_CNT_EN
    logic [NUM_IN*CNT_W-1:0] grant_cnt;
`endif

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
`ifdef ROUTER_MERGE_GRANT_CNT_EN
        , input grant_cnt
`endif
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
`ifdef ROUTER_MERGE_GRANT_CNT_EN
        , output grant_cnt
`endif
    );

endinterface

// File: rtl/rr_arbiter_5.sv
// Combinational five-way round-robin winner select: the first request found
// searching upward from ptr (wrapping 4->0) wins. Nothing is granted when en=0.
module rr_arbiter_5 (
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    input  logic       en,
    output logic [4:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_any
);

    logic [3:0] idx;

    // Scan the five positions in priority order, keeping the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        if (en) begin
            for (int k = 0; k < 5; k++) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'd5) idx = idx - 4'd5;
                if (!gnt_any && req[idx[2:0]]) begin
                    gnt[idx[2:0]] = 1'b1;
                    gnt_idx       = idx[2:0];
                    gnt_any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_merge_arb_5.sv
// Output-side merge stage: round-robin over W,N,S,E,P into a one-entry
// registered output slot. Optional ROUTER_MERGE_GRANT_CNT_EN adds saturating
// per-source grant counters.
//
// Slot FSM
//   state    | meaning
//   ST_EMPTY | no packet held, out_valid=0
//   ST_FULL  | packet held on out_data, out_valid=1
module router_merge_arb_5
    import router_pkg::*;
#(
    parameter int WIDTH  = PKT_W,
    parameter int NUM_IN = 5
`ifdef ROUTER_MERGE_GRANT_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic rst,
    router_merge_arb_5_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       slot_state;
    logic [WIDTH-1:0] out_data_q;
    logic [2:0]       rr_ptr;
    logic             slot_free;
    logic [4:0]       gnt;
    logic [2:0]       gnt_idx;
    logic             gnt_any;

    assign slot_free = (slot_state == ST_EMPTY) || bus.out_ready;

    // Arbitration is gated by reset so nothing is accepted while rst is low.
    rr_arbiter_5 u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .en      (rst && slot_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.in_ready  = gnt;
    assign bus.out_valid = (slot_state == ST_FULL);
    assign bus.out_data  = out_data_q;

    // Output slot and pointer: load on grant (also covers drain+load), else drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_state <= ST_EMPTY;
            out_data_q <= '0;
            rr_ptr     <= '0;
        end else if (gnt_any) begin
            slot_state <= ST_FULL;
            out_data_q <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
            rr_ptr     <= next_ptr(gnt_idx);
        end else if (slot_state == ST_FULL && bus.out_ready) begin
            slot_state <= ST_EMPTY;
        end
    end

`ifdef ROUTER_MERGE_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_IN];

    // Count accepted transfers per source, holding at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
        end else if (gnt_any && (cnt_q[gnt_idx] != '1)) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
        assign bus.grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: doc/router_merge_arb_5.md
Name: router_merge_arb_5

Overview:
- Output-side merge stage of the 5-port mesh router; sits directly downstream of the per-input split stages.
- Collects the packets that the split stages steer towards one output link, from up to five sources: W, N, S, E and the local PE.
- Applies round-robin arbitration and drives that single output link through a one-entry registered output slot with a valid/ready handshake.
- One instance per router output port (five per router).

Parameters:
- WIDTH, 34: packet width in bits; destination X in [29:28], destination Y in [27:26].
- NUM_IN, 5: number of requesters; fixed at 5; index 0=W, 1=N, 2=S, 3=E, 4=P.
- CNT_W, 16: width of each grant counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- in_data  in  NUM_IN*WIDTH  packed input packets; source i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-source request.
- in_ready  out  NUM_IN  per-source grant/accept, combinational, one-hot or zero.
- out_data  out  WIDTH  registered output packet.
- out_valid  out  1  registered; output slot holds a packet.
- out_ready  in  1  downstream accepts out_data this cycle.
- grant_cnt  out  NUM_IN*CNT_W  per-source accepted-packet counts (present only with ROUTER_MERGE_GRANT_CNT_EN).

Behaviour:
- All state updates on posedge clk. rst is sampled only at clk edges; rst=0 takes priority over everything.
- Reset values: out_valid=0, out_data=0, rr_ptr=0, counters=0. in_ready is combinationally 0 while rst=0.
- Slot free: slot_free = !out_valid || out_ready.
- Arbitration is combinational and evaluated each cycle only when slot_free=1:
  - Search in_valid starting at index rr_ptr, ascending with wrap 4->0.
  - The first set bit is the winner g; in_ready[g]=1 and all other in_ready bits are 0.
  - If slot_free=0 or no request is present, in_ready=0.
- Transfer: in_valid[g] && in_ready[g] at a clock edge gives out_data<=in_data[g], out_valid<=1, rr_ptr<=(g==4)?0:g+1.
- Drain: out_ready && out_valid with no new grant gives out_valid<=0. out_data holds its last value.
- Simultaneous drain and grant in the same cycle: new packet loaded and out_valid stays 1. Full throughput is 1 packet/cycle.
- Stall: out_valid && !out_ready. out_data and out_valid are held and in_ready=0 for every source.
- Latency: a packet accepted at edge k is visible on out_data/out_valid after edge k.
- Packets are passed unmodified; the block does no address decode.
- Fairness: a source that holds in_valid is granted within 5 consecutive slot-free grant cycles.
- Sources must hold in_valid and in_data stable until accepted. Behaviour is undefined if a source violates this.
- Reset mid-operation: any packet held in the slot is discarded, rr_ptr returns to 0, and nothing is sent on the cycle reset is asserted.
- State summary: the slot FSM has two states.
  - EMPTY -> FULL on grant.
  - FULL -> FULL on drain+grant or on stall.
  - FULL -> EMPTY on drain without grant.

Optional Feature:
- Macro: ROUTER_MERGE_GRANT_CNT_EN.
- Defined:
  - grant_cnt port exists.
  - Counter i increments by 1 on each accepted transfer from source i.
  - Counters saturate at 2^CNT_W-1 (no wrap).
  - Reset to 0 by rst.
- Undefined: port and counters are absent; arbitration and handshake behaviour are identical to the defined case.

Decomposition:
- Shared package router_pkg holds:
  - PKT_W=34, X_HI=29, X_LO=28, Y_HI=27, Y_LO=26.
  - Direction localparams WEST=2'b00, NORTH=2'b01, SOUTH=2'b10, EAST=2'b11.
  - Port index constants IDX_W..IDX_P.
- One sub-module, rr_arbiter_5: a purely combinational round-robin winner select.
  - Inputs: req[4:0], ptr[2:0], en.
  - Outputs: gnt[4:0] one-hot, gnt_idx[2:0], gnt_any.
- rr_ptr, the output slot and the counters stay in the top module.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with in_valid=5'b11111 -> in_ready=0 and out_valid=0 throughout; out_data=0.
- Single source: N (idx 1) presents 34'h0_1400_0001 with out_ready=1 -> in_ready=5'b00010 that cycle; next cycle out_data=34'h0_1400_0001, out_valid=1; rr_ptr=2.
- Round-robin: all five sources valid continuously from reset, out_ready=1 -> grant order W,N,S,E,P,W,...; one packet per cycle; no source granted twice within 5 cycles.
- Backpressure: slot full, out_ready=0 for 4 cycles with E and P requesting -> out_data stable, in_ready=0 throughout. Release out_ready -> E granted same cycle (if rr_ptr<=3) with drain+load; out_valid stays 1.
- Reset mid-stall: slot full with out_ready=0, assert rst=0 for one edge -> out_valid=0 next cycle; after release, first grant is the lowest valid index.
- ROUTER_MERGE_GRANT_CNT_EN, CNT_W=4: S sends 20 packets -> grant_cnt[S] saturates at 15; others remain 0.
